// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl
// Purpose     : receive-side frame alignment controller. It hunts the line byte stream for the
//               FAS, confirms lock (HUNT/PRESYNC/SYNC), and tags each byte with its row/column.
// Latency     : 1 cycle from i_frame_data to o_frame_data.
// Backpressure: none. i_frame_data_valid qualifies each byte, and idle cycles hold all state.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_frame_data[7:0]       line byte, qualified by i_frame_data_valid
//   o_frame_data[7:0]       input byte delayed by one cycle
//   o_frame_data_valid      byte was valid and the controller was in SYNC for it
//   o_row_cnt / o_col_cnt   row/column of the byte on o_frame_data
//   o_frame_start           valid byte at row 0, column 0
//   o_in_frame / o_lof      registered SYNC / HUNT status, one cycle behind the state
module frame_align_ctrl #(
   parameter int         NUM_ROWS = 4,
   parameter int         NUM_COLS = 1041,
   parameter logic [7:0] FAS_A    = 8'hF6,
   parameter logic [7:0] FAS_B    = 8'h28,
   parameter int         LOSS_CNT = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_frame_data,
   input  logic        i_frame_data_valid,
   output logic [7:0]  o_frame_data,
   output logic        o_frame_data_valid,
   output logic [1:0]  o_row_cnt,
   output logic [10:0] o_col_cnt,
   output logic        o_frame_start,
   output logic        o_in_frame,
   output logic        o_lof
);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PRESYNC = 2'd1,
      ST_SYNC    = 2'd2
   } state_t;

   localparam logic [1:0]  ROW_LAST  = 2'(NUM_ROWS - 1);
   localparam logic [10:0] COL_LAST  = 11'(NUM_COLS - 1);
   // The byte that completes the FAS is, by definition, row 0 column 5.
   localparam logic [10:0] CHK_COL   = 11'd5;
   localparam logic [10:0] ACQ_COL   = 11'd6;
   localparam logic [2:0]  LOSS_LIM  = 3'(LOSS_CNT);
   localparam logic [47:0] FAS_PATTERN = {FAS_A, FAS_A, FAS_A, FAS_B, FAS_B, FAS_B};

   // Alignment state
   state_t      state_q, state_d;
   logic [39:0] hist_q, hist_d;      // last five valid bytes, newest in the low byte
   logic [1:0]  row_q, row_d;        // position of the current input byte
   logic [10:0] col_q, col_d;
   logic [2:0]  miss_q, miss_d;      // consecutive checkpoint misses while in SYNC

   // Output registers
   logic [7:0]  dat_out_q;
   logic        vld_out_q;
   logic [1:0]  row_out_q;
   logic [10:0] col_out_q;
   logic        start_out_q;
   logic        in_frame_q;
   logic        lof_q;

   // Helper terms
   logic        fas_match;
   logic        at_checkpoint;
   logic [1:0]  row_fly;
   logic [10:0] col_fly;
   logic [2:0]  miss_inc;

   always_comb begin
      fas_match     = ({hist_q, i_frame_data} == FAS_PATTERN);
      at_checkpoint = (row_q == 2'd0) && (col_q == CHK_COL);
      miss_inc      = miss_q + 3'd1;
   end

   // Flywheel: the position of the next byte when the counters free-run.
   always_comb begin
      row_fly = row_q;
      col_fly = col_q + 11'd1;
      if (col_q == COL_LAST) begin
         col_fly = 11'd0;
         row_fly = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;
      end
   end

   // History shift register: only valid bytes enter the pattern window.
   always_comb begin
      hist_d = hist_q;
      if (i_frame_data_valid) begin
         hist_d = {hist_q[31:0], i_frame_data};
      end
   end

   // Next-state logic. All transitions and counter moves are gated by a valid byte.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      miss_d  = miss_q;

      if (i_frame_data_valid) begin
         case (state_q)
            ST_HUNT: begin
               // Counters are parked at 0 while hunting. On a match, the next byte is
               // row 0 column 6.
               row_d = 2'd0;
               col_d = 11'd0;
               if (fas_match) begin
                  state_d = ST_PRESYNC;
                  col_d   = ACQ_COL;
               end
            end

            ST_PRESYNC: begin
               row_d = row_fly;
               col_d = col_fly;
               // Off-checkpoint patterns are ignored, so there is no realignment outside HUNT.
               if (at_checkpoint) begin
                  if (fas_match) begin
                     state_d = ST_SYNC;
                     miss_d  = 3'd0;
                  end else begin
                     state_d = ST_HUNT;
                     row_d   = 2'd0;
                     col_d   = 11'd0;
                  end
               end
            end

            ST_SYNC: begin
               row_d = row_fly;
               col_d = col_fly;
               if (at_checkpoint) begin
                  if (fas_match) begin
                     miss_d = 3'd0;
                  end else if (miss_inc >= LOSS_LIM) begin
                     // This checkpoint byte is still forwarded as valid because the output
                     // qualifier uses the state before this update.
                     state_d = ST_HUNT;
                     row_d   = 2'd0;
                     col_d   = 11'd0;
                     miss_d  = 3'd0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               row_d   = 2'd0;
               col_d   = 11'd0;
               miss_d  = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_HUNT;
         hist_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         row_q   <= row_d;
         col_q   <= col_d;
         miss_q  <= miss_d;
      end
   end

   // Output stage. The data qualifier and frame start use the pre-update state and position
   // of the byte being forwarded. The status flags track the state register one cycle later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dat_out_q   <= '0;
         vld_out_q   <= 1'b0;
         row_out_q   <= '0;
         col_out_q   <= '0;
         start_out_q <= 1'b0;
         in_frame_q  <= 1'b0;
         lof_q       <= 1'b1;
      end else begin
         in_frame_q <= (state_q == ST_SYNC);
         lof_q      <= (state_q == ST_HUNT);
         if (i_frame_data_valid) begin
            dat_out_q   <= i_frame_data;
            row_out_q   <= row_q;
            col_out_q   <= col_q;
            vld_out_q   <= (state_q == ST_SYNC);
            start_out_q <= (state_q == ST_SYNC) && (row_q == 2'd0) && (col_q == 11'd0);
         end else begin
            vld_out_q   <= 1'b0;
            start_out_q <= 1'b0;
         end
      end
   end

   assign o_frame_data       = dat_out_q;
   assign o_frame_data_valid = vld_out_q;
   assign o_row_cnt          = row_out_q;
   assign o_col_cnt          = col_out_q;
   assign o_frame_start      = start_out_q;
   assign o_in_frame         = in_frame_q;
   assign o_lof              = lof_q;

   // Structural invariants of the controller
   a_start_implies_valid : assert property (@(posedge i_clk) disable iff (i_rst)
      o_frame_start |-> o_frame_data_valid);
   a_status_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
      !(o_in_frame && o_lof));
   a_valid_implies_in_frame : assert property (@(posedge i_clk) disable iff (i_rst)
      o_frame_data_valid |-> o_in_frame);
   a_miss_below_limit : assert property (@(posedge i_clk) disable iff (i_rst)
      miss_q < LOSS_LIM);

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl
// Purpose     : directed frame streams into frame_align_ctrl. A scoreboard queue holds every
//               byte expected on the output together with the cycle it is due.
// Latency     : the monitor expects each valid output exactly one cycle after its input byte.
// Backpressure: none. Idle gaps are inserted by the stimulus only.
module tb_frame_align_ctrl;

   localparam int NCOLS = 1041;
   localparam int LAST  = 4 * NCOLS - 1;   // 4163: last byte index of a frame
   localparam int NONE  = 99999;           // v_first value that selects no valid bytes

   typedef struct {
      logic [7:0]  dat;
      logic [1:0]  row;
      logic [10:0] col;
      logic        start;
      int          due;
   } exp_t;

   logic        i_clk;
   logic        i_rst;
   logic [7:0]  i_frame_data;
   logic        i_frame_data_valid;
   logic [7:0]  o_frame_data;
   logic        o_frame_data_valid;
   logic [1:0]  o_row_cnt;
   logic [10:0] o_col_cnt;
   logic        o_frame_start;
   logic        o_in_frame;
   logic        o_lof;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [7:0]  pay      = 8'h00;

   frame_align_ctrl dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_frame_data       (i_frame_data),
      .i_frame_data_valid (i_frame_data_valid),
      .o_frame_data       (o_frame_data),
      .o_frame_data_valid (o_frame_data_valid),
      .o_row_cnt          (o_row_cnt),
      .o_col_cnt          (o_col_cnt),
      .o_frame_start      (o_frame_start),
      .o_in_frame         (o_in_frame),
      .o_lof              (o_lof)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: every valid output must match the oldest expected byte and arrive on time.
   always @(negedge i_clk) begin
      if (o_frame_data_valid === 1'b1) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: cyc=%0d dat=%02h row=%0d col=%0d, required no valid output",
                     cyc, o_frame_data, o_row_cnt, o_col_cnt);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (o_frame_data !== e.dat || o_row_cnt !== e.row || o_col_cnt !== e.col ||
                o_frame_start !== e.start || cyc != e.due) begin
               n_fail++;
               $display("FAIL out_byte: got dat=%02h row=%0d col=%0d start=%b cyc=%0d, required dat=%02h row=%0d col=%0d start=%b cyc=%0d",
                        o_frame_data, o_row_cnt, o_col_cnt, o_frame_start, cyc,
                        e.dat, e.row, e.col, e.start, e.due);
            end
         end
      end else if (o_frame_start === 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL start_without_valid: o_frame_start=1 with o_frame_data_valid=%b, required 0",
                  o_frame_data_valid);
      end
   end

   task automatic idle(input int n);
      i_frame_data_valid = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   // Send frame byte indices first..last. FAS occupies row 0 columns 0..5, and the payload is an
   // incrementing byte. bad_col inverts that FAS byte. Bytes with index in [v_first, v_last]
   // are expected on the output.
   task automatic send_seg(input int first, input int last, input int bad_col,
                           input int v_first, input int v_last, input bit gaps);
      for (int idx = first; idx <= last; idx++) begin
         int         row;
         int         col;
         logic [7:0] d;
         exp_t       e;
         if (gaps && ($urandom_range(0, 7) == 0)) idle(int'($urandom_range(1, 3)));
         row = idx / NCOLS;
         col = idx % NCOLS;
         if (row == 0 && col < 6) begin
            d = (col < 3) ? 8'hF6 : 8'h28;
         end else begin
            d   = pay;
            pay = pay + 8'd1;
         end
         if (row == 0 && col == bad_col) d = d ^ 8'hFF;
         i_frame_data       = d;
         i_frame_data_valid = 1'b1;
         if (idx >= v_first && idx <= v_last) begin
            e.dat   = d;
            e.row   = 2'(row);
            e.col   = 11'(col);
            e.start = (idx == 0);
            e.due   = cyc + 1;
            sb_q.push_back(e);
         end
         @(negedge i_clk);
      end
      i_frame_data_valid = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string name, input logic exp_lof, input logic exp_in);
      n_checks++;
      if (o_lof !== exp_lof || o_in_frame !== exp_in) begin
         n_fail++;
         $display("FAIL %s: o_lof=%b o_in_frame=%b, required o_lof=%b o_in_frame=%b",
                  name, o_lof, o_in_frame, exp_lof, exp_in);
      end
   endtask

   task automatic check_drained(input string name);
      idle(2);
      chk(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dat"},   32'(o_frame_data),       32'h0);
      chk({tag, "_vld"},   32'(o_frame_data_valid), 32'h0);
      chk({tag, "_row"},   32'(o_row_cnt),          32'h0);
      chk({tag, "_col"},   32'(o_col_cnt),          32'h0);
      chk({tag, "_start"}, 32'(o_frame_start),      32'h0);
      chk({tag, "_inf"},   32'(o_in_frame),         32'h0);
      chk({tag, "_lof"},   32'(o_lof),              32'h1);
   endtask

   // Three clean frames from HUNT: lock is confirmed at frame 2 column 5, data flows from
   // frame 2 column 6 onward, and frame 3 column 0 carries the frame start.
   task automatic acquire(input string tag);
      send_seg(0, 5, -1, NONE, 0, 1'b0);
      check_status({tag, "_lof_lag"}, 1'b1, 1'b0);
      send_seg(6, 6, -1, NONE, 0, 1'b0);
      check_status({tag, "_lof_fall"}, 1'b0, 1'b0);
      send_seg(7, LAST, -1, NONE, 0, 1'b0);
      send_seg(0, 5, -1, 6, LAST, 1'b0);
      check_status({tag, "_presync"}, 1'b0, 1'b0);
      send_seg(6, 6, -1, 6, LAST, 1'b0);
      check_status({tag, "_sync_rise"}, 1'b0, 1'b1);
      send_seg(7, LAST, -1, 6, LAST, 1'b0);
      send_seg(0, LAST, -1, 0, LAST, 1'b0);
      check_status({tag, "_locked"}, 1'b0, 1'b1);
   endtask

   initial begin
      i_rst              = 1'b1;
      i_frame_data       = 8'h00;
      i_frame_data_valid = 1'b0;
      repeat (2) @(negedge i_clk);
      check_reset_outputs("reset");
      i_rst = 1'b0;
      idle(2);

      // Acquisition
      acquire("acq");

      // Valid gaps across a whole frame, including the row 3 col 1040 -> row 0 col 0 wrap
      send_seg(0, LAST, -1, 0, LAST, 1'b1);
      send_seg(0, 0, -1, 0, 0, 1'b0);
      send_seg(1, LAST, -1, 1, LAST, 1'b1);
      check_status("gaps_locked", 1'b0, 1'b1);

      // Single FAS error: lock is held, then a clean frame clears the miss counter
      send_seg(0, LAST, 4, 0, LAST, 1'b0);
      check_status("single_err", 1'b0, 1'b1);
      send_seg(0, LAST, -1, 0, LAST, 1'b0);

      // Loss of frame: three consecutive bad checkpoints; the third one is still forwarded
      send_seg(0, LAST, 4, 0, LAST, 1'b0);
      send_seg(0, LAST, 2, 0, LAST, 1'b0);
      check_status("miss2_locked", 1'b0, 1'b1);
      send_seg(0, 5, 5, 0, 5, 1'b0);
      check_status("lof_lag", 1'b0, 1'b1);
      send_seg(6, 6, -1, NONE, 0, 1'b0);
      check_status("lof_rise", 1'b1, 1'b0);
      send_seg(7, LAST, -1, NONE, 0, 1'b0);
      check_drained("lof_drained");

      // False lock: a FAS in HUNT, then no FAS one frame later
      send_seg(0, 5, -1, NONE, 0, 1'b0);
      send_seg(6, 6, -1, NONE, 0, 1'b0);
      check_status("false_presync", 1'b0, 1'b0);
      send_seg(7, LAST, -1, NONE, 0, 1'b0);
      send_seg(0, 5, 0, NONE, 0, 1'b0);
      check_status("false_lag", 1'b0, 1'b0);
      send_seg(6, 6, -1, NONE, 0, 1'b0);
      check_status("false_back_hunt", 1'b1, 1'b0);
      check_drained("false_drained");

      // Reset mid-frame at row 2 column 500 while in SYNC
      send_seg(0, LAST, -1, NONE, 0, 1'b0);
      send_seg(0, 2 * NCOLS + 499, -1, 6, LAST, 1'b0);
      check_status("pre_reset_locked", 1'b0, 1'b1);
      i_frame_data       = 8'hF6;
      i_frame_data_valid = 1'b1;
      i_rst              = 1'b1;
      @(negedge i_clk);
      check_reset_outputs("midrst");
      i_rst              = 1'b0;
      i_frame_data_valid = 1'b0;
      check_drained("midrst_drained");

      // Re-acquisition behaves exactly like the first acquisition
      acquire("reacq");
      check_drained("final_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_align_ctrl.md
Name: frame_align_ctrl

Overview:
- Receive-side frame alignment controller that sequences the demapper write-enable stage.
- Hunts the line byte stream for the frame alignment signal (FAS) and confirms frame lock with a HUNT/PRESYNC/SYNC state machine.
- Runs flywheel row/column counters and forwards each byte one cycle later with its row/column position.
- Gates data valid so the downstream demapper sees only in-frame bytes; also reports lock/loss status.

Parameters:
- NUM_ROWS, 4, rows per frame; o_row_cnt wraps NUM_ROWS-1 -> 0.
- NUM_COLS, 1041, bytes per row (columns 0..1040); o_col_cnt wraps NUM_COLS-1 -> 0.
- FAS_A, 8'hF6, value of FAS bytes at columns 0..2 of row 0.
- FAS_B, 8'h28, value of FAS bytes at columns 3..5 of row 0.
- LOSS_CNT, 3, consecutive FAS misses in SYNC that force HUNT (range 1..7).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high; clock is i_clk.
- i_frame_data  in  8  line byte.
- i_frame_data_valid  in  1  qualifies i_frame_data.
- o_frame_data  out  8  delayed byte to the demapper.
- o_frame_data_valid  out  1  byte valid AND the controller was in SYNC for that byte.
- o_row_cnt  out  2  row of the byte on o_frame_data.
- o_col_cnt  out  11  column of the byte on o_frame_data.
- o_frame_start  out  1  one-cycle pulse when the byte on o_frame_data is row 0, column 0 and is valid.
- o_in_frame  out  1  state == SYNC (registered).
- o_lof  out  1  loss of frame: state == HUNT (registered).

Behaviour:
- Reset values:
  - all data/count outputs 0; o_frame_data_valid 0; o_frame_start 0; o_in_frame 0; o_lof 1.
  - state HUNT; internal counters 0; miss counter 0; 40-bit history register 0.
- Reset mid-frame: same values on the next edge, no partial state kept.
- Valid bytes:
  - Only cycles with i_frame_data_valid=1 advance the history register, counters or checks.
  - On an invalid cycle, o_frame_data_valid=0 and o_frame_start=0; o_frame_data, counts and state hold.
- Pattern match:
  - The last 5 valid bytes plus the current byte, oldest first, equal FAS_A,FAS_A,FAS_A,FAS_B,FAS_B,FAS_B.
  - The current byte is by definition row 0, column 5.
- Internal counters (row r, col c): position of the current input byte.
  - Each valid byte: c increments; at NUM_COLS-1, c -> 0 and r increments mod NUM_ROWS.
  - In HUNT, counters hold 0 until lock is acquired.
- Latency:
  - Exactly 1 cycle.
  - On every valid input: o_frame_data <= i_frame_data, o_row_cnt <= r, o_col_cnt <= c.
  - o_frame_data_valid <= (state==SYNC), evaluated with the state before this cycle's update.
- State machine (transitions only on valid bytes):
  - HUNT, pattern match: r<=0, c<=6 for the next byte; -> PRESYNC.
  - PRESYNC, checkpoint (r==0 and c==5): match -> SYNC with miss counter 0; mismatch -> HUNT with counters 0.
  - SYNC, checkpoint match: miss counter <= 0.
  - SYNC, checkpoint mismatch: miss counter +1; at LOSS_CNT -> HUNT with counters 0.
  - SYNC, before LOSS_CNT is reached: counters flywheel and data keeps flowing.
- Boundary rules:
  - The checkpoint byte that causes the SYNC->HUNT exit is still output valid; the following bytes are not.
  - Patterns away from a checkpoint are ignored in PRESYNC and SYNC (no realignment outside HUNT).
  - A checkpoint that is a valid match is never also treated as a HUNT trigger.
  - If the first checkpoint byte after acquisition arrives after valid gaps, only the valid-byte count matters (4164 valid bytes per frame at default parameters).
- o_in_frame and o_lof update one cycle after a state change.

Test Plan:
- Acquisition:
  - Stimulus: reset, then 3 clean frames (FAS at row 0, columns 0..5, payload incrementing).
  - Required: o_lof falls one cycle after frame 1 column 5; o_in_frame rises after frame 2 column 5.
  - Required: first o_frame_data_valid=1 on frame 2 row 0 column 6 with o_col_cnt=6, o_row_cnt=0; o_frame_start pulses at frame 3 column 0.
- Valid gaps:
  - Stimulus: in SYNC, insert 1-3 idle cycles randomly.
  - Required: counts advance only on valid bytes; row 3 column 1040 -> row 0 column 0; output always 1 cycle after the input.
- Single FAS error:
  - Stimulus: in SYNC, corrupt byte at column 4 of one frame.
  - Required: o_in_frame stays 1; data stays valid; the next clean FAS clears the miss counter.
- Loss of frame:
  - Stimulus: corrupt FAS in 3 consecutive frames.
  - Required: third checkpoint byte output valid; o_frame_data_valid=0 from the next byte; o_lof=1 one cycle after the third checkpoint.
- False lock:
  - Stimulus: in HUNT, a FAS-like pattern inside payload, then no FAS 4164 bytes later.
  - Required: PRESYNC then back to HUNT; o_frame_data_valid never asserted.
- Reset mid-frame:
  - Stimulus: assert i_rst during SYNC at row 2 column 500.
  - Required: next cycle all outputs at reset values, o_lof=1; re-acquisition identical to the acquisition scenario.
